dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-port synchronous data memory (12-bit address, 32-bit word) between two requesters: the processor load/store port and a board-reader port. The board reader is the display/scan logic that fetches board squares to drive the LED/Pmod pins. The CPU has priority. A starvation counter forces a one-cycle CPU stall so the reader is always served. The block sits inside Wrapper between processor, dmem and the board display logic.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 32, memory word width
MAX_WAIT, 8, maximum consecutive denied reader-request cycles before a forced grant (must be >= 1)
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDR_W  CPU access address
cpu_wdata  in  DATA_W  CPU store data
cpu_we  in  1  CPU store request
cpu_re  in  1  CPU load request
cpu_rdata  out  DATA_W  load data; equals mem_rdata (pass-through)
cpu_stall  out  1  CPU must hold its request this cycle
rd_req  in  1  reader request; held until rd_ack
rd_addr  in  ADDR_W  reader address
rd_ack  out  1  reader granted this cycle (combinational)
rd_valid  out  1  rd_data valid (registered, one cycle after rd_ack)
rd_data  out  DATA_W  reader data; equals mem_rdata
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data; always cpu_wdata
mem_we  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data, one-cycle latency

Behaviour:
- Reset values: state=NORMAL, wait_cnt=0, owner_q=NONE, rd_valid=0. While reset is high: mem_we=0, rd_ack=0, cpu_stall=0.
- Definition: cpu_act = cpu_re | cpu_we.
- NORMAL state:
  - If cpu_act: CPU is granted. mem_addr=cpu_addr, mem_we=cpu_we, rd_ack=0.
  - Else if rd_req: reader is granted. mem_addr=rd_addr, mem_we=0, rd_ack=1.
  - Else: no grant. mem_we=0, mem_addr=cpu_addr.
- wait_cnt:
  - Increments on each cycle with rd_req=1 and rd_ack=0.
  - Clears on rd_ack or rd_req=0.
  - Saturates at MAX_WAIT.
- NORMAL -> FORCE when the next value of wait_cnt equals MAX_WAIT.
- FORCE state (always exactly one cycle, then returns to NORMAL; wait_cnt<=0):
  - If rd_req: reader is granted with rd_ack=1 and mem_we=0. cpu_stall=1 if cpu_act, else cpu_stall=0.
  - If rd_req dropped: behaves as NORMAL, with no stall.
- A CPU store colliding with FORCE is suppressed (mem_we=0). The CPU holds the store under stall, and the store is performed in the next cycle.
- owner_q registers the current grant: RD, CPU or NONE.
- rd_valid = (owner_q==RD), one cycle after rd_ack. rd_data = mem_rdata.
- cpu_stall is never asserted in NORMAL. It is never asserted two consecutive cycles.
- Reset asserted mid-transaction: owner_q goes to NONE asynchronously. No rd_valid is produced for a grant issued before reset.
- Worst-case reader latency from rd_req rise to rd_ack: MAX_WAIT+1 cycles.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - ADDR_W and DATA_W defaults
  - owner enum {OWN_NONE, OWN_CPU, OWN_RD}
  - state enum {ST_NORMAL, ST_FORCE}
- One sub-module, starve_counter, implements the saturating wait counter with inc/clr inputs and a hit output. It is parameterised by MAX_WAIT and WAIT_W.

Test Plan:
- Reader alone:
  - Stimulus: dmem[0x010]=0xDEADBEEF; rd_req=1, rd_addr=0x010, CPU idle.
  - Response: rd_ack=1 the same cycle; next cycle rd_valid=1, rd_data=0xDEADBEEF; cpu_stall never asserted.
- Collision, CPU wins:
  - Stimulus: cpu_we=1, cpu_addr=0x020, cpu_wdata=0x12345678 with rd_req=1 in the same cycle.
  - Response: mem_we=1, mem_addr=0x020, rd_ack=0; wait_cnt=1 after the edge.
- Starvation:
  - Stimulus: cpu_re=1 continuously, rd_req=1, rd_addr=0x030.
  - Response: rd_ack=0 for 8 cycles; on cycle 9 cpu_stall=1 and rd_ack=1 with mem_addr=0x030; cycle 10 has cpu_stall=0 and rd_valid=1.
- Forced grant during store:
  - Stimulus: as the starvation case, but cpu_we=1 to 0x040 with 0xCAFEF00D held under stall.
  - Response: mem_we=0 in the FORCE cycle; mem_we=1 at 0x040 in the next cycle; readback returns 0xCAFEF00D.
- Request dropped:
  - Stimulus: rd_req high for 5 denied cycles, low for 1 cycle, high again with the CPU busy.
  - Response: the forced grant occurs only after 8 further denied cycles.
- Reset mid-operation:
  - Stimulus: rd_ack issued, then reset pulsed before the next rising edge.
  - Response: rd_valid stays 0; wait_cnt=0; first post-reset reader request is acked immediately when the CPU is idle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 8;
  localparam int DEF_WAIT_W   = 4;

  // Who was granted the memory port in a given cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_RD   = 2'd2
  } owner_t;

  // Arbiter FSM: NORMAL (CPU priority) or FORCE (one-cycle reader grant).
  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU port, the board reader, the data memory and
// the arbiter. The arbiter uses the slave modport; the surroundings
// (processor, board display logic, dmem) drive the master side.
//
// Reader handshake: rd_req is a request that the reader holds stable
// (together with rd_addr) until it sees rd_ack high in the same cycle; the
// transfer happens on the rising edge where rd_req & rd_ack are both high.
// rd_valid follows exactly one cycle later with rd_data. CPU side: when
// cpu_stall is high the CPU must hold cpu_re/cpu_we/cpu_addr/cpu_wdata for
// the next cycle.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WAIT_W = DEF_WAIT_W
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Debug view of internal state.
  logic [0:0]        dbg_state;
  logic [WAIT_W-1:0] dbg_wait_cnt;
  owner_t            dbg_owner;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, rd_req, rd_addr, mem_rdata,
    output cpu_rdata, cpu_stall, rd_ack, rd_valid, rd_data,
           mem_addr, mem_wdata, mem_we,
           dbg_state, dbg_wait_cnt, dbg_owner
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, rd_req, rd_addr, mem_rdata,
    input  cpu_rdata, cpu_stall, rd_ack, rd_valid, rd_data,
           mem_addr, mem_wdata, mem_we,
           dbg_state, dbg_wait_cnt, dbg_owner
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles in which the reader was denied.
// hit flags that the count is about to reach MAX_WAIT (MAX_WAIT >= 1 and
// 2**WAIT_W > MAX_WAIT are required).
module starve_counter #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic              hit,
  output logic [WAIT_W-1:0] cnt
);

  localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment up to MAX_WAIT and hold.
  always_comb begin
    cnt_d = cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt_d = cnt + 1'b1;
    end
    hit = (cnt_d == MAX_C);
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store port
// (priority) and the board reader. After MAX_WAIT consecutive denied reader
// cycles the arbiter spends one FORCE cycle granting the reader and
// stalling the CPU, so the reader is served within MAX_WAIT+1 cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int WAIT_W   = DEF_WAIT_W
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [0:0] S_NORMAL = 1'(ST_NORMAL);
  localparam logic [0:0] S_FORCE  = 1'(ST_FORCE);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  owner_t            owner_q;
  owner_t            grant;
  logic              cpu_act;
  logic              force_grant;
  logic              ack;
  logic              we;
  logic              stall;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              cnt_hit;
  logic [WAIT_W-1:0] wait_cnt;

  assign cpu_act     = bus.cpu_re | bus.cpu_we;
  assign force_grant = (state_q == S_FORCE) && bus.rd_req;

  // Grant selection. FORCE with a live request goes to the reader and
  // suppresses any CPU store; otherwise the CPU has priority. Reset gates
  // every side-effecting output.
  always_comb begin
    addr  = bus.cpu_addr;
    we    = 1'b0;
    ack   = 1'b0;
    stall = 1'b0;
    grant = OWN_NONE;
    if (force_grant) begin
      addr  = bus.rd_addr;
      ack   = 1'b1;
      stall = cpu_act;
      grant = OWN_RD;
    end else if (cpu_act) begin
      we    = bus.cpu_we;
      grant = OWN_CPU;
    end else if (bus.rd_req) begin
      addr  = bus.rd_addr;
      ack   = 1'b1;
      grant = OWN_RD;
    end
    if (reset) begin
      we    = 1'b0;
      ack   = 1'b0;
      stall = 1'b0;
      grant = OWN_NONE;
    end
  end

  // Starvation tracking: count denied reader cycles; any ack, idle reader
  // or FORCE cycle restarts the count.
  assign cnt_inc = bus.rd_req & ~ack;
  assign cnt_clr = ~cnt_inc | (state_q == S_FORCE);

  starve_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_starve_counter (
    .clock (clock),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .hit   (cnt_hit),
    .cnt   (wait_cnt)
  );

  // FSM next state: FORCE lasts exactly one cycle.
  always_comb begin
    state_d = S_NORMAL;
    if ((state_q == S_NORMAL) && cnt_hit) begin
      state_d = S_FORCE;
    end
  end

  // State and grant-owner registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_NORMAL;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= grant;
    end
  end

  assign wdata = bus.cpu_wdata;

  assign bus.mem_addr     = addr;
  assign bus.mem_wdata    = wdata;
  assign bus.mem_we       = we;
  assign bus.rd_ack       = ack;
  assign bus.cpu_stall    = stall;
  assign bus.cpu_rdata    = bus.mem_rdata;
  assign bus.rd_data      = bus.mem_rdata;
  assign bus.rd_valid     = (owner_q == OWN_RD);
  assign bus.dbg_state    = state_q;
  assign bus.dbg_wait_cnt = wait_cnt;
  assign bus.dbg_owner    = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle table of inputs and expected
// outputs, a reader-data scoreboard, and a hand-written reset sequence.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [11:0] caddr;
    logic [31:0] wdata;
    logic        rreq;
    logic [11:0] raddr;
    logic        e_we;
    logic [11:0] e_addr;
    logic        e_ack;
    logic        e_stall;
    logic        e_valid;
    logic [3:0]  e_wait;
    logic [31:0] rdat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] dmem [0:4095];

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32), .WAIT_W(4)) bus ();

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(8), .WAIT_W(4)) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port memory, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= dmem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rd_valid check plus scoreboard pop of the expected reader data.
  task automatic check_valid(input string name, input logic exp);
    logic [31:0] e;
    chk({name, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp));
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s.rd_data: got %h expected no transfer", name, bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        chk({name, ".rd_data"}, bus.rd_data, e);
      end
    end
  endtask

  task automatic add(input logic re, input logic we, input logic [11:0] caddr,
                     input logic [31:0] wdata, input logic rreq, input logic [11:0] raddr,
                     input logic e_we, input logic [11:0] e_addr, input logic e_ack,
                     input logic e_stall, input logic e_valid, input logic [3:0] e_wait,
                     input logic [31:0] rdat);
    vec_t v;
    v = '{re, we, caddr, wdata, rreq, raddr, e_we, e_addr, e_ack, e_stall, e_valid, e_wait, rdat};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 12'h000;
    bus.cpu_wdata = 32'h0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = 12'h000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //   re we caddr   wdata          rq raddr    we  addr    ak st vl wait  rdat
    add(0, 0, 12'h000, 32'h0,         0, 12'h000, 0, 12'h000, 0, 0, 0, 4'd0, 32'h0);
    add(0, 1, 12'h010, 32'hDEADBEEF,  0, 12'h000, 1, 12'h010, 0, 0, 0, 4'd0, 32'h0);
    add(0, 1, 12'h030, 32'hA5A50030,  0, 12'h000, 1, 12'h030, 0, 0, 0, 4'd0, 32'h0);
    add(0, 1, 12'h060, 32'h60606060,  0, 12'h000, 1, 12'h060, 0, 0, 0, 4'd0, 32'h0);
    // Reader alone.
    add(0, 0, 12'h000, 32'h0,         1, 12'h010, 0, 12'h010, 1, 0, 0, 4'd0, 32'hDEADBEEF);
    add(0, 0, 12'h000, 32'h0,         0, 12'h000, 0, 12'h000, 0, 0, 1, 4'd0, 32'h0);
    // Collision, CPU store wins, then starvation under continuous loads.
    add(0, 1, 12'h020, 32'h12345678,  1, 12'h030, 1, 12'h020, 0, 0, 0, 4'd1, 32'h0);
    for (int i = 2; i <= 8; i++)
      add(1, 0, 12'h050, 32'h0,       1, 12'h030, 0, 12'h050, 0, 0, 0, 4'(i), 32'h0);
    add(1, 0, 12'h050, 32'h0,         1, 12'h030, 0, 12'h030, 1, 1, 0, 4'd0, 32'hA5A50030);
    add(1, 0, 12'h050, 32'h0,         0, 12'h000, 0, 12'h050, 0, 0, 1, 4'd0, 32'h0);
    // Forced grant colliding with a store.
    for (int i = 1; i <= 8; i++)
      add(1, 0, 12'h050, 32'h0,       1, 12'h060, 0, 12'h050, 0, 0, 0, 4'(i), 32'h0);
    add(0, 1, 12'h040, 32'hCAFEF00D,  1, 12'h060, 0, 12'h060, 1, 1, 0, 4'd0, 32'h60606060);
    add(0, 1, 12'h040, 32'hCAFEF00D,  0, 12'h000, 1, 12'h040, 0, 0, 1, 4'd0, 32'h0);
    add(0, 0, 12'h000, 32'h0,         1, 12'h040, 0, 12'h040, 1, 0, 0, 4'd0, 32'hCAFEF00D);
    add(0, 0, 12'h000, 32'h0,         0, 12'h000, 0, 12'h000, 0, 0, 1, 4'd0, 32'h0);
    // Request dropped after 5 denials restarts the count.
    for (int i = 1; i <= 5; i++)
      add(1, 0, 12'h050, 32'h0,       1, 12'h030, 0, 12'h050, 0, 0, 0, 4'(i), 32'h0);
    add(1, 0, 12'h050, 32'h0,         0, 12'h030, 0, 12'h050, 0, 0, 0, 4'd0, 32'h0);
    for (int i = 1; i <= 8; i++)
      add(1, 0, 12'h050, 32'h0,       1, 12'h030, 0, 12'h050, 0, 0, 0, 4'(i), 32'h0);
    add(1, 0, 12'h050, 32'h0,         1, 12'h030, 0, 12'h030, 1, 1, 0, 4'd0, 32'hA5A50030);
    add(0, 0, 12'h000, 32'h0,         0, 12'h000, 0, 12'h000, 0, 0, 1, 4'd0, 32'h0);

    // Reset with active requests on both sides.
    rst = 1'b1;
    drive_idle();
    bus.cpu_we = 1'b1;
    bus.rd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.mem_we",    32'(bus.mem_we),       32'd0);
    chk("reset.rd_ack",    32'(bus.rd_ack),       32'd0);
    chk("reset.cpu_stall", 32'(bus.cpu_stall),    32'd0);
    chk("reset.rd_valid",  32'(bus.rd_valid),     32'd0);
    chk("reset.wait_cnt",  32'(bus.dbg_wait_cnt), 32'd0);
    chk("reset.state",     32'(bus.dbg_state),    32'd0);
    drive_idle();
    rst = 1'b0;

    // Table-driven cycles.
    foreach (vecs[i]) begin
      vec_t v;
      string n;
      v = vecs[i];
      n = $sformatf("v%0d", i);
      bus.cpu_re    = v.re;
      bus.cpu_we    = v.we;
      bus.cpu_addr  = v.caddr;
      bus.cpu_wdata = v.wdata;
      bus.rd_req    = v.rreq;
      bus.rd_addr   = v.raddr;
      if (v.e_ack) exp_q.push_back(v.rdat);
      #4;
      chk({n, ".mem_we"},    32'(bus.mem_we),    32'(v.e_we));
      chk({n, ".mem_addr"},  32'(bus.mem_addr),  32'(v.e_addr));
      chk({n, ".rd_ack"},    32'(bus.rd_ack),    32'(v.e_ack));
      chk({n, ".cpu_stall"}, 32'(bus.cpu_stall), 32'(v.e_stall));
      if (v.we) chk({n, ".mem_wdata"}, bus.mem_wdata, v.wdata);
      check_valid(n, v.e_valid);
      @(posedge clk);
      #1;
      chk({n, ".wait_cnt"}, 32'(bus.dbg_wait_cnt), 32'(v.e_wait));
    end

    // Reset pulsed right after an ack: that grant must never yield rd_valid.
    bus.rd_req  = 1'b1;
    bus.rd_addr = 12'h010;
    #4;
    chk("rst_mid.pre_ack", 32'(bus.rd_ack), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.ack",   32'(bus.rd_ack),    32'd0);
    chk("rst_mid.we",    32'(bus.mem_we),    32'd0);
    chk("rst_mid.stall", 32'(bus.cpu_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid.wait_cnt", 32'(bus.dbg_wait_cnt), 32'd0);
    check_valid("rst_mid.c0", 1'b0);
    rst = 1'b0;
    bus.rd_req = 1'b0;
    #4;
    check_valid("rst_mid.c1", 1'b0);
    @(posedge clk);
    #1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 12'h030;
    exp_q.push_back(32'hA5A50030);
    #4;
    chk("post_rst.ack",  32'(bus.rd_ack),  32'd1);
    chk("post_rst.addr", 32'(bus.mem_addr), 32'h030);
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    #4;
    check_valid("post_rst", 1'b1);
    chk("scoreboard.left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
